// File: rtl/console_uart_tx.sv
// Memory-mapped console transmitter: picorv32 native-bus stores fill a TX FIFO drained by an 8N1 serializer.
// Optional CONSOLE_SIM_PRINT_EN echoes every accepted byte with $write for simulation.
module console_uart_tx #(
    parameter logic [31:0] ADDR_DATA    = 32'h1000_0000,
    parameter logic [31:0] ADDR_STAT    = 32'h1000_0004,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_next;
    logic [2:0]         bit_idx, bit_idx_next;
    logic [7:0]         shift_reg, shift_next;
    logic               tx_next;
    logic               pop;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   fifo_level;
    logic               fifo_full, fifo_empty;

    logic               sel_data, sel_stat, hit;
    logic               push_req, stat_rd, accept, push;
    logic [31:0]        status;
    logic               unused_wdata;

    assign unused_wdata = ^mem_wdata[31:8];

    assign sel_data = (mem_addr == ADDR_DATA);
    assign sel_stat = (mem_addr == ADDR_STAT);
    assign hit      = mem_valid && (sel_data || sel_stat);
    assign push_req = sel_data && mem_wstrb[0];
    assign stat_rd  = sel_stat && (mem_wstrb == 4'b0000);

    // Fullness comes from the registered level, so a pop never lets a push through in the same cycle.
    assign accept = hit && !mem_ready && !(push_req && fifo_full);
    assign push   = accept && push_req;

    assign fifo_full  = (fifo_level == LVL_FULL);
    assign fifo_empty = (fifo_level == '0);
    assign tx_busy    = !fifo_empty || (state != S_IDLE);
    assign status     = {16'd0, 8'(fifo_level), 5'd0, tx_busy, fifo_empty, fifo_full};

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= accept;
            mem_rdata <= (accept && stat_rd) ? status : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Payload storage carries no reset; the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
        shift_reg <= shift_next;
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        pop          = 1'b0;
        tx_next      = 1'b1;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_next   = fifo_mem[rd_ptr];
                    bit_cnt_next = BIT_LAST;
                    state_next   = S_START;
                end
            end
            S_START: begin
                tx_next = 1'b0;
                if (bit_cnt == '0) begin
                    bit_cnt_next = BIT_LAST;
                    bit_idx_next = 3'd0;
                    state_next   = S_DATA;
                end else begin
                    bit_cnt_next = bit_cnt - 1'b1;
                end
            end
            S_DATA: begin
                tx_next = shift_reg[0];
                if (bit_cnt == '0) begin
                    bit_cnt_next = BIT_LAST;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) state_next = S_STOP;
                    else                 bit_idx_next = bit_idx + 1'b1;
                end else begin
                    bit_cnt_next = bit_cnt - 1'b1;
                end
            end
            S_STOP: begin
                tx_next = 1'b1;
                if (bit_cnt == '0) begin
                    // Chain straight into the next start bit so frames stay gapless.
                    if (!fifo_empty) begin
                        pop          = 1'b1;
                        shift_next   = fifo_mem[rd_ptr];
                        bit_cnt_next = BIT_LAST;
                        state_next   = S_START;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    bit_cnt_next = bit_cnt - 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Line is registered: it lags the FSM state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            bit_idx <= bit_idx_next;
            uart_tx <= tx_next;
        end
    end

`ifdef CONSOLE_SIM_PRINT_EN
    always_ff @(posedge clk) begin
        if (!reset && push) $write("%c", mem_wdata[7:0]);
    end
`else
`endif

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed self-checking bench for console_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_console_uart_tx;

    localparam logic [31:0] A_DATA = 32'h1000_0000;
    localparam logic [31:0] A_STAT = 32'h1000_0004;
    localparam logic [31:0] A_BAD  = 32'h1000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        tx_busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic cap_en = 1'b0;
    logic cap_q[$];

    console_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .uart_tx  (uart_tx),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line recorder: one sample per cycle, 2 ns after the edge that produced it.
    always @(posedge clk) begin
        #2;
        if (cap_en) cap_q.push_back(uart_tx);
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output int waits, output logic [31:0] rdata);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        waits     = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (mem_ready !== 1'b1 && waits < 400);
        rdata = mem_rdata;
        chk("bus_ack", 64'(mem_ready), 64'd1);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    // 10 bits (start, LSB-first data, stop), each held 4 cycles; bit k of result = sample k.
    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [9:0]  f;
        logic [39:0] r;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int c = 0; c < 4; c++) r[4*i+c] = f[i];
        return r;
    endfunction

    initial begin
        int          w [6];
        int          wt;
        int          n0;
        int          guard;
        int          lows;
        int          busys;
        int          acks;
        logic [31:0] rd;
        logic [39:0] obs;
        logic [7:0]  bytes6 [6];

        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;

        // Reset
        repeat (5) @(negedge clk);
        chk("rst_uart_tx", 64'(uart_tx), 64'd1);
        chk("rst_ready", 64'(mem_ready), 64'd0);
        chk("rst_busy", 64'(tx_busy), 64'd0);
        chk("rst_rdata", 64'(mem_rdata), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        bus_xfer(A_STAT, 32'h0, 4'h0, wt, rd);
        chk("rst_stat", 64'(rd), 64'h2);
        chk("rst_stat_lat", 64'(wt), 64'd1);
        @(negedge clk);
        chk("stat_ready_drop", 64'(mem_ready), 64'd0);
        chk("stat_rdata_drop", 64'(mem_rdata), 64'd0);

        // Single 0x41 frame
        bus_xfer(A_DATA, 32'h41, 4'hF, wt, rd);
        chk("wr41_lat", 64'(wt), 64'd1);
        @(negedge clk);
        chk("wr41_one_cycle_ack", 64'(mem_ready), 64'd0);
        chk("wr41_line_before_start", 64'(uart_tx), 64'd1);
        chk("wr41_busy", 64'(tx_busy), 64'd1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            obs[k] = uart_tx;
        end
        chk("wr41_frame", 64'(obs), 64'(frame_bits(8'h41)));
        chk("wr41_busy_end", 64'(tx_busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("wr41_idle_line", 64'(uart_tx), 64'd1);

        // Six back-to-back writes; the sixth stalls until the second byte is popped
        cap_q.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bytes6[i] = 8'h30 + 8'(i);
            bus_xfer(A_DATA, {24'h0, bytes6[i]}, 4'hF, w[i], rd);
        end
        chk("b2b_wait1", 64'(w[0]), 64'd1);
        chk("b2b_wait2", 64'(w[1]), 64'd2);
        chk("b2b_wait5", 64'(w[4]), 64'd2);
        chk("b2b_wait6_stall", 64'(w[5]), 64'd34);
        guard = 0;
        while (tx_busy === 1'b1 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk("b2b_drain", 64'(tx_busy), 64'd0);
        repeat (5) @(negedge clk);
        cap_en = 1'b0;
        chk("b2b_cap_len", 64'(cap_q.size() >= 246), 64'd1);
        chk("b2b_lead", 64'({cap_q[1], cap_q[0]}), 64'h3);
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 40; k++) obs[k] = cap_q[2 + 40*f + k];
            chk($sformatf("b2b_frame%0d", f), 64'(obs), 64'(frame_bits(bytes6[f])));
        end
        chk("b2b_tail", 64'({cap_q[245], cap_q[244], cap_q[243], cap_q[242]}), 64'hF);

        // Status with 3 bytes queued behind a frame in flight
        bus_xfer(A_DATA, 32'h55, 4'hF, wt, rd);
        n0 = cyc;
        for (int i = 0; i < 3; i++) bus_xfer(A_DATA, 32'h00, 4'hF, wt, rd);
        bus_xfer(A_STAT, 32'h0, 4'h0, wt, rd);
        chk("stat_q3", 64'(rd), 64'h0304);
        chk("stat_q3_lat", 64'(wt), 64'd2);
        @(negedge clk);
        chk("stat_q3_drop", 64'(mem_rdata), 64'd0);
        mem_valid = 1'b1;
        mem_addr  = A_BAD;
        mem_wstrb = 4'h0;
        acks = 0;
        repeat (10) begin
            @(negedge clk);
            if (mem_ready !== 1'b0) acks++;
        end
        mem_valid = 1'b0;
        chk("bad_addr_no_ack", 64'(acks), 64'd0);

        // Reset in the middle of the second (all-zero) frame with a read pending
        guard = 0;
        while (cyc != n0 + 55 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk("mid_frame_reached", 64'(cyc - n0), 64'd55);
        chk("mid_frame_line_low", 64'(uart_tx), 64'd0);
        chk("mid_frame_busy", 64'(tx_busy), 64'd1);
        reset     = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = A_STAT;
        mem_wstrb = 4'h0;
        @(negedge clk);
        chk("rst_mid_line", 64'(uart_tx), 64'd1);
        chk("rst_mid_busy", 64'(tx_busy), 64'd0);
        chk("rst_mid_ready0", 64'(mem_ready), 64'd0);
        @(negedge clk);
        chk("rst_mid_ready1", 64'(mem_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_reack", 64'(mem_ready), 64'd1);
        chk("rst_mid_stat", 64'(mem_rdata), 64'h2);
        mem_valid = 1'b0;
        lows  = 0;
        busys = 0;
        repeat (60) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
            if (tx_busy !== 1'b0) busys++;
        end
        chk("rst_mid_no_frames", 64'(lows), 64'd0);
        chk("rst_mid_stays_idle", 64'(busys), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
